// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings for the RV32I memory-access stage
package mem_stage_pkg;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;
  localparam logic [1:0] WD_IMM = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    MS_IDLE,
    MS_WAIT
  } ms_state_t;

  // Halves need off[0] clear, words need both offset bits clear.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if ((funct3 == F3_H || funct3 == F3_HU) && off[0]) bad = 1'b1;
    if (funct3 == F3_W && off != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane formatting and load extraction
// Purely combinational; funct3 selects byte/half/word handling.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word[{off, 3'b000} +: 8];
  assign ld_half = ld_word[{off[1], 4'b0000} +: 16];

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (funct3)
      F3_B: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h000000, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0000, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory stage: data-bus handshake, stall and MEM/WB register
// Optional MEM_MISALIGN_CHK_EN blocks misaligned accesses and flags them in WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         MEM_WdSel_i,
  input  logic               MEM_DMwe_i,
  input  logic               MEM_RFwe_i,
  input  logic [31:0]        MEM_pc4_i,
  input  logic [31:0]        MEM_ALUc_i,
  input  logic [31:0]        MEM_imm_i,
  input  logic [31:0]        MEM_rd2_i,
  input  logic [4:0]         MEM_rd_i,
  input  logic [31:0]        MEM_inst_i,
  output logic               dm_req_o,
  output logic               dm_we_o,
  output logic [31:0]        dm_addr_o,
  output logic [3:0]         dm_be_o,
  output logic [31:0]        dm_wdata_o,
  input  logic               dm_ready_i,
  input  logic [31:0]        dm_rdata_i,
  output logic               mem_stop_o,
  output logic [31:0]        WB_wd_o,
  output logic [4:0]         WB_rd_o,
  output logic               WB_RFwe_o,
  output logic [31:0]        WB_inst_o,
`ifdef MEM_MISALIGN_CHK_EN
  output logic               WB_misalign_o,
`endif
  output logic [STALL_W-1:0] stall_cnt_o
);

  ms_state_t   state_q, state_d;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        access;
  logic        go;
  logic        mis;
  logic        req;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic [31:0] wd;

  assign funct3 = MEM_inst_i[14:12];
  assign off    = MEM_ALUc_i[1:0];
  assign access = MEM_DMwe_i | (MEM_WdSel_i == WD_DM);

`ifdef MEM_MISALIGN_CHK_EN
  assign mis = access & misaligned(funct3, off);
`else
  assign mis = 1'b0;
`endif
  assign go = access & ~mis;

  mem_align u_align (
    .funct3   (funct3),
    .off      (off),
    .st_data  (MEM_rd2_i),
    .ld_word  (dm_rdata_i),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      MS_IDLE: begin
        req = go;
        if (go && !dm_ready_i) state_d = MS_WAIT;
      end
      MS_WAIT: begin
        req = 1'b1;
        if (dm_ready_i) state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // Stall is combinational so a zero-wait memory never costs a cycle.
  assign dm_req_o   = req;
  assign dm_we_o    = req & MEM_DMwe_i;
  assign mem_stop_o = req & ~dm_ready_i;
  assign dm_addr_o  = {MEM_ALUc_i[31:2], 2'b00};
  assign dm_be_o    = MEM_DMwe_i ? st_be : 4'b1111;
  assign dm_wdata_o = st_wdata;

  always_comb begin
    wd = MEM_ALUc_i;
    case (MEM_WdSel_i)
      WD_ALU:  wd = MEM_ALUc_i;
      WD_DM:   wd = ld_data;
      WD_PC4:  wd = MEM_pc4_i;
      default: wd = MEM_imm_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_wd_o   <= '0;
      WB_rd_o   <= '0;
      WB_RFwe_o <= 1'b0;
      WB_inst_o <= '0;
    end else if (mem_stop_o) begin
      WB_RFwe_o <= 1'b0;
    end else begin
      WB_wd_o   <= wd;
      WB_rd_o   <= MEM_rd_i;
      WB_RFwe_o <= MEM_RFwe_i & ~mis;
      WB_inst_o <= MEM_inst_i;
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          WB_misalign_o <= 1'b0;
    else if (mem_stop_o) WB_misalign_o <= 1'b0;
    else                 WB_misalign_o <= mis;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_cnt_o <= '0;
    else if (mem_stop_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline. Sits between the EX/MEM pipeline register and the register-file write port. Drives a request/ready data-memory bus, formats byte/half/word stores and loads, and stalls upstream until the access completes. Selects the write-back value and registers it into the MEM/WB pipeline register.

## Interface
Parameters:
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MEM_WdSel_i  in  2  write-back select: 00 ALU result, 01 load data, 10 pc+4, 11 immediate.
- MEM_DMwe_i  in  1  store.
- MEM_RFwe_i  in  1  register-file write enable.
- MEM_pc4_i, MEM_ALUc_i, MEM_imm_i, MEM_rd2_i  in  32 each  pc+4, ALU result (memory address), immediate, store data.
- MEM_rd_i  in  5  destination register.
- MEM_inst_i  in  32  instruction; funct3 = bits [14:12].
- dm_req_o  out  1  memory request.
- dm_we_o  out  1  write request.
- dm_addr_o  out  32  word address, {MEM_ALUc_i[31:2], 2'b00}.
- dm_be_o  out  4  byte enables.
- dm_wdata_o  out  32  lane-replicated store data.
- dm_ready_i  in  1  access complete this cycle; dm_rdata_i valid when it is high.
- dm_rdata_i  in  32  read word.
- mem_stop_o  out  1  stall to PC, IF/ID, ID/EX and EX/MEM registers.
- WB_wd_o  out  32  registered write-back data.
- WB_rd_o  out  5  registered destination.
- WB_RFwe_o  out  1  registered write enable.
- WB_inst_o  out  32  registered instruction.
- stall_cnt_o  out  STALL_W  total stall cycles, saturating.
- WB_misalign_o  out  1  registered misaligned-access flag; only present with MEM_MISALIGN_CHK_EN.

## Operation
- access = MEM_DMwe_i | (MEM_WdSel_i == 01).
- FSM with two states:
  - IDLE: go to WAIT on access & !dm_ready_i.
  - WAIT: go to IDLE on dm_ready_i.
- dm_req_o = (IDLE & access) | WAIT.
- dm_we_o = dm_req_o & MEM_DMwe_i.
- mem_stop_o = dm_req_o & !dm_ready_i. This is combinational, so a zero-wait memory causes no stall.
- EX/MEM inputs are held stable by mem_stop_o. The request stays asserted with unchanged fields until ready is seen.
- Store format, with off = addr[1:0]:
  - sb (000): be = 0001<<off, wdata = {4{rd2[7:0]}}.
  - sh (001): be = 0011<<(2*off[1]), wdata = {2{rd2[15:0]}}.
  - sw (010): be = 1111, wdata = rd2.
- Load be is always 1111. Load extraction from dm_rdata_i:
  - lb/lbu (000/100): byte at off, sign- or zero-extended.
  - lh/lhu (001/101): half at off[1], sign- or zero-extended.
  - lw (010): full word.
  - Other funct3 values are treated as lw.
- Write-back data = mux(MEM_WdSel_i) of {ALUc, load data, pc4, imm}.
- MEM/WB register, each cycle:
  - If mem_stop_o: load a bubble (WB_RFwe_o = 0; other WB fields hold).
  - Else: load wd, rd, RFwe, inst.
- stall_cnt_o increments on every cycle with mem_stop_o = 1 and saturates at all-ones.

## Timing
- Reset: state IDLE. WB_wd_o, WB_rd_o, WB_RFwe_o, WB_inst_o, stall_cnt_o and WB_misalign_o are all 0. dm_* and mem_stop_o follow the combinational rules.
- Latency: the access completes in the cycle where dm_ready_i = 1. WB outputs update on the next rising edge.
- An N-cycle wait gives exactly N stall cycles and exactly one WB write.
- Reset asserted in WAIT aborts the access: state returns to IDLE and no WB write occurs.
- dm_ready_i high with no request is ignored.

## Configuration
- MEM_MISALIGN_CHK_EN defined:
  - A misaligned access (lh/lhu/sh with off[0] = 1, or lw/sw with off != 0) suppresses dm_req_o and causes no stall.
  - The WB register loads RFwe = 0 and WB_misalign_o = 1 for one cycle.
- Not defined:
  - The WB_misalign_o port is absent and no check is performed.
  - Misaligned halves use off[1] only; misaligned words ignore off.

## Structure
- The shared package holds:
  - WdSel encodings: WD_ALU, WD_DM, WD_PC4, WD_IMM.
  - funct3 load/store constants.
  - The FSM state enum: MS_IDLE, MS_WAIT.
- One sub-module, mem_align: purely combinational. Produces store be/wdata and load extraction from funct3, off and the data words.

## Test plan
- sw, addr 0x104, rd2 0xDEADBEEF, dm_ready_i = 1 same cycle -> dm_be_o 1111, dm_addr_o 0x104, no stall.
- sb, addr 0x103, rd2 0x000000A5 -> be 1000, wdata 0xA5A5A5A5.
- lb, addr 0x102, rdata 0x12F0_3456, WdSel 01, rd 5 -> WB_wd_o 0xFFFFFFF0 one cycle later. Repeating with lbu gives 0x000000F0.
- lw with ready delayed 3 cycles -> mem_stop_o high 3 cycles, stall_cnt_o = 3, exactly one WB_RFwe_o pulse with rdata.
- rst_n asserted in WAIT -> all WB outputs 0, state IDLE, no request after release until a new access.
- With MEM_MISALIGN_CHK_EN, lw at 0x102 -> dm_req_o 0, WB_misalign_o 1, WB_RFwe_o 0.
